// File: rtl/hack_data_memory.sv
// rtl/hack_data_memory.sv - Hack CPU data memory: RAM, screen buffer, key FIFO, keyboard status
//
// Purpose:
//   Data-memory subsystem directly downstream of the CPU. CPU reads are
//   combinational and CPU writes complete at the clock edge, so there is no
//   CPU-side stall. A registered read-only port serves the display scanner.
//   A valid/ready port fills a small keyboard FIFO.
//
// Memory map (a = addressM[14:0]):
//   0x0000-0x3FFF  general RAM
//   0x4000-0x5FFF  screen buffer
//   0x6000         KBD   : read = FIFO head (0 when empty), write = pop
//   0x6001         KSTAT : read = {overflow, 10'b0, count[4:0]},
//                          write with outM[15]=1 clears overflow
//   other          reads return 0, writes are ignored
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   addressM     CPU data address (bit 15 ignored)
//   outM         CPU write data
//   wen          CPU write enable
//   inM          CPU read data, combinational from addressM
//   key_valid    keyboard source offers key_code
//   key_code     key code, 0 means "no key"
//   key_ready    FIFO can accept a key (from registered count only)
//   scr_addr     display scanner word address
//   scr_data     screen word, registered, one-cycle latency
//   kbd_overflow sticky flag, a non-zero key was offered while full

module hack_data_memory #(
  parameter int RAM_WORDS    = 16384,
  parameter int SCREEN_WORDS = 8192,
  parameter int KBD_DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addressM,
  input  logic [15:0] outM,
  input  logic        wen,
  output logic [15:0] inM,
  input  logic        key_valid,
  input  logic [15:0] key_code,
  output logic        key_ready,
  input  logic [12:0] scr_addr,
  output logic [15:0] scr_data,
  output logic        kbd_overflow
);

  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam int SCR_AW = $clog2(SCREEN_WORDS);
  localparam int PTR_W  = $clog2(KBD_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(KBD_DEPTH);

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [15:0] ram    [RAM_WORDS];
  logic [15:0] screen [SCREEN_WORDS];
  logic [15:0] fifo   [KBD_DEPTH];

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [14:0] a;
  logic        is_ram;
  logic        is_scr;
  logic        is_kbd;
  logic        is_kstat;

  assign a        = addressM[14:0];
  assign is_ram   = (a < 15'h4000);
  assign is_scr   = (a >= 15'h4000) && (a <= 15'h5FFF);
  assign is_kbd   = (a == 15'h6000);
  assign is_kstat = (a == 15'h6001);

  // Bit 15 of the CPU address is deliberately ignored.
  logic unused_addr_bit;
  assign unused_addr_bit = addressM[15];

  logic [RAM_AW-1:0] ram_idx;
  logic [SCR_AW-1:0] scr_idx;
  assign ram_idx = a[RAM_AW-1:0];
  assign scr_idx = a[SCR_AW-1:0];

  // ---------------------------------------------------------------------------
  // Key FIFO control
  // ---------------------------------------------------------------------------
  logic       key_nonzero;
  logic       fifo_empty;
  logic       do_push;
  logic       do_pop;
  logic       ovf_set;
  logic       ovf_clr;
  logic [4:0] count5;

  assign key_nonzero = (key_code != 16'h0000);
  assign fifo_empty  = (count == '0);

  // Ready depends only on the registered count, never on a same-cycle pop,
  // so a full FIFO refuses a key even while the CPU is draining it.
  assign key_ready = (count < DEPTH_C);

  assign do_push = ~reset & key_valid & key_ready & key_nonzero;
  assign do_pop  = ~reset & wen & is_kbd & ~fifo_empty;
  assign ovf_set = key_valid & ~key_ready & key_nonzero;
  assign ovf_clr = wen & is_kstat & outM[15];

  assign count5 = 5'(count);

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      kbd_overflow <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      // Simultaneous push and pop leaves the occupancy unchanged.
      if (do_push && !do_pop) begin
        count <= count + CNT_W'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CNT_W'(1);
      end
      // A new drop in the same cycle as a software clear must stay visible.
      if (ovf_set) begin
        kbd_overflow <= 1'b1;
      end else if (ovf_clr) begin
        kbd_overflow <= 1'b0;
      end
    end
  end

  // FIFO slots hold no reset value; occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_push) begin
      fifo[wr_ptr] <= key_code;
    end
  end

  // ---------------------------------------------------------------------------
  // RAM and screen writes (contents survive reset)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset && wen && is_ram) begin
      ram[ram_idx] <= outM;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && wen && is_scr) begin
      screen[scr_idx] <= outM;
    end
  end

  // ---------------------------------------------------------------------------
  // Scanner port: nonblocking read of the array yields the pre-write word when
  // the CPU writes the same location in the same cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      scr_data <= 16'h0000;
    end else begin
      scr_data <= screen[scr_addr[SCR_AW-1:0]];
    end
  end

  // ---------------------------------------------------------------------------
  // CPU read mux
  // ---------------------------------------------------------------------------
  always_comb begin
    inM = 16'h0000;
    if (is_ram) begin
      inM = ram[ram_idx];
    end else if (is_scr) begin
      inM = screen[scr_idx];
    end else if (is_kbd) begin
      inM = fifo_empty ? 16'h0000 : fifo[rd_ptr];
    end else if (is_kstat) begin
      inM = {kbd_overflow, 10'b0, count5};
    end
  end

endmodule

// File: tb/tb_hack_data_memory.sv
// tb/tb_hack_data_memory.sv - directed self-checking bench for hack_data_memory

module tb_hack_data_memory;

  logic        clk;
  logic        reset;
  logic [15:0] addressM;
  logic [15:0] outM;
  logic        wen;
  logic [15:0] inM;
  logic        key_valid;
  logic [15:0] key_code;
  logic        key_ready;
  logic [12:0] scr_addr;
  logic [15:0] scr_data;
  logic        kbd_overflow;

  int checks;
  int failures;

  hack_data_memory dut (
    .clk          (clk),
    .reset        (reset),
    .addressM     (addressM),
    .outM         (outM),
    .wen          (wen),
    .inM          (inM),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .key_ready    (key_ready),
    .scr_addr     (scr_addr),
    .scr_data     (scr_data),
    .kbd_overflow (kbd_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [15:0] addr, input logic [15:0] data);
    addressM = addr;
    outM     = data;
    wen      = 1'b1;
    tick();
    wen      = 1'b0;
  endtask

  task automatic push_key(input logic [15:0] code);
    key_valid = 1'b1;
    key_code  = code;
    tick();
    key_valid = 1'b0;
    key_code  = 16'h0000;
  endtask

  task automatic rd(input logic [15:0] addr);
    addressM = addr;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if (key_ready !== 1'b1) begin
      failures++; $display("FAIL reset_key_ready got=%b exp=1", key_ready);
    end
    checks++;
    if (kbd_overflow !== 1'b0) begin
      failures++; $display("FAIL reset_overflow got=%b exp=0", kbd_overflow);
    end
    checks++;
    if (scr_data !== 16'h0000) begin
      failures++; $display("FAIL reset_scr_data got=%h exp=0000", scr_data);
    end
    rd(16'h6001);
    checks++;
    if (inM !== 16'h0000) begin
      failures++; $display("FAIL reset_kstat got=%h exp=0000", inM);
    end
    rd(16'h6000);
    checks++;
    if (inM !== 16'h0000) begin
      failures++; $display("FAIL reset_kbd got=%h exp=0000", inM);
    end
  endtask

  task automatic test_ram();
    cpu_write(16'h0010, 16'h1234);
    rd(16'h0010);
    checks++;
    if (inM !== 16'h1234) begin
      failures++; $display("FAIL ram_readback got=%h exp=1234", inM);
    end
    rd(16'h8010);
    checks++;
    if (inM !== 16'h1234) begin
      failures++; $display("FAIL ram_bit15_ignored got=%h exp=1234", inM);
    end
    cpu_write(16'h3FFF, 16'hA5A5);
    rd(16'h3FFF);
    checks++;
    if (inM !== 16'hA5A5) begin
      failures++; $display("FAIL ram_top_word got=%h exp=a5a5", inM);
    end
    rd(16'h6002);
    checks++;
    if (inM !== 16'h0000) begin
      failures++; $display("FAIL unmapped_6002 got=%h exp=0000", inM);
    end
    rd(16'h7FFF);
    checks++;
    if (inM !== 16'h0000) begin
      failures++; $display("FAIL unmapped_7fff got=%h exp=0000", inM);
    end
    cpu_write(16'h7000, 16'hBEEF);
    rd(16'h7000);
    checks++;
    if (inM !== 16'h0000) begin
      failures++; $display("FAIL unmapped_write got=%h exp=0000", inM);
    end
    rd(16'h0010);
    checks++;
    if (inM !== 16'h1234) begin
      failures++; $display("FAIL ram_after_unmapped got=%h exp=1234", inM);
    end
    rd(16'h6001);
    checks++;
    if (inM !== 16'h0000) begin
      failures++; $display("FAIL kstat_after_unmapped got=%h exp=0000", inM);
    end
  endtask

  task automatic test_screen();
    scr_addr = 13'd5;
    cpu_write(16'h4005, 16'hFFFF);
    rd(16'h4005);
    checks++;
    if (inM !== 16'hFFFF) begin
      failures++; $display("FAIL scr_cpu_read got=%h exp=ffff", inM);
    end
    tick();
    checks++;
    if (scr_data !== 16'hFFFF) begin
      failures++; $display("FAIL scr_port_read got=%h exp=ffff", scr_data);
    end
    cpu_write(16'h4005, 16'h0000);
    checks++;
    if (scr_data !== 16'hFFFF) begin
      failures++; $display("FAIL scr_read_before_write got=%h exp=ffff", scr_data);
    end
    tick();
    checks++;
    if (scr_data !== 16'h0000) begin
      failures++; $display("FAIL scr_after_write got=%h exp=0000", scr_data);
    end
  endtask

  task automatic test_fifo_basic();
    push_key(16'd65);
    push_key(16'd66);
    rd(16'h6001);
    checks++;
    if (inM !== 16'h0002) begin
      failures++; $display("FAIL fifo_kstat2 got=%h exp=0002", inM);
    end
    rd(16'h6000);
    checks++;
    if (inM !== 16'd65) begin
      failures++; $display("FAIL fifo_head65 got=%h exp=0041", inM);
    end
    cpu_write(16'h6000, 16'h1234);
    rd(16'h6000);
    checks++;
    if (inM !== 16'd66) begin
      failures++; $display("FAIL fifo_head66 got=%h exp=0042", inM);
    end
    cpu_write(16'h6000, 16'h0000);
    cpu_write(16'h6000, 16'h0000);
    rd(16'h6000);
    checks++;
    if (inM !== 16'h0000) begin
      failures++; $display("FAIL fifo_empty_kbd got=%h exp=0000", inM);
    end
    rd(16'h6001);
    checks++;
    if (inM !== 16'h0000) begin
      failures++; $display("FAIL fifo_empty_kstat got=%h exp=0000", inM);
    end
  endtask

  task automatic test_full_overflow();
    for (int i = 0; i < 4; i++) push_key(16'(71 + i));
    checks++;
    if (key_ready !== 1'b0) begin
      failures++; $display("FAIL full_key_ready got=%b exp=0", key_ready);
    end
    push_key(16'd70);
    checks++;
    if (kbd_overflow !== 1'b1) begin
      failures++; $display("FAIL overflow_set got=%b exp=1", kbd_overflow);
    end
    rd(16'h6001);
    checks++;
    if (inM !== 16'h8004) begin
      failures++; $display("FAIL kstat_8004 got=%h exp=8004", inM);
    end
    rd(16'h6000);
    checks++;
    if (inM !== 16'd71) begin
      failures++; $display("FAIL full_head got=%h exp=0047", inM);
    end
    cpu_write(16'h6001, 16'h0000);
    rd(16'h6001);
    checks++;
    if (inM !== 16'h8004) begin
      failures++; $display("FAIL kstat_no_clear got=%h exp=8004", inM);
    end
    cpu_write(16'h6001, 16'h8000);
    rd(16'h6001);
    checks++;
    if (inM !== 16'h0004) begin
      failures++; $display("FAIL kstat_cleared got=%h exp=0004", inM);
    end
    // Set and clear in the same cycle: set wins.
    key_valid = 1'b1;
    key_code  = 16'd70;
    cpu_write(16'h6001, 16'h8000);
    key_valid = 1'b0;
    checks++;
    if (kbd_overflow !== 1'b1) begin
      failures++; $display("FAIL set_wins got=%b exp=1", kbd_overflow);
    end
    cpu_write(16'h6001, 16'h8000);
    // Full with a same-cycle pop: no push, key counts as dropped.
    key_valid = 1'b1;
    key_code  = 16'd75;
    cpu_write(16'h6000, 16'h0000);
    key_valid = 1'b0;
    rd(16'h6001);
    checks++;
    if (inM !== 16'h8003) begin
      failures++; $display("FAIL full_pop_kstat got=%h exp=8003", inM);
    end
    rd(16'h6000);
    checks++;
    if (inM !== 16'd72) begin
      failures++; $display("FAIL full_pop_head got=%h exp=0048", inM);
    end
    cpu_write(16'h6001, 16'h8000);
    for (int i = 0; i < 3; i++) cpu_write(16'h6000, 16'h0000);
    rd(16'h6001);
    checks++;
    if (inM !== 16'h0000) begin
      failures++; $display("FAIL drained_kstat got=%h exp=0000", inM);
    end
  endtask

  task automatic test_back_to_back();
    push_key(16'd80);
    push_key(16'd81);
    key_valid = 1'b1;
    key_code  = 16'd67;
    cpu_write(16'h6000, 16'h0000);
    key_valid = 1'b0;
    rd(16'h6001);
    checks++;
    if (inM !== 16'h0002) begin
      failures++; $display("FAIL pushpop_count got=%h exp=0002", inM);
    end
    rd(16'h6000);
    checks++;
    if (inM !== 16'd81) begin
      failures++; $display("FAIL pushpop_head got=%h exp=0051", inM);
    end
    key_valid = 1'b1;
    key_code  = 16'h0000;
    #1;
    checks++;
    if (key_ready !== 1'b1) begin
      failures++; $display("FAIL zero_code_ready got=%b exp=1", key_ready);
    end
    tick();
    key_valid = 1'b0;
    rd(16'h6001);
    checks++;
    if (inM !== 16'h0002) begin
      failures++; $display("FAIL zero_code_count got=%h exp=0002", inM);
    end
    cpu_write(16'h6000, 16'h0000);
    rd(16'h6000);
    checks++;
    if (inM !== 16'd67) begin
      failures++; $display("FAIL order_67 got=%h exp=0043", inM);
    end
    cpu_write(16'h6000, 16'h0000);
  endtask

  task automatic test_reset_mid();
    cpu_write(16'h0020, 16'hCAFE);
    cpu_write(16'h4006, 16'h5A5A);
    scr_addr = 13'd6;
    for (int i = 1; i <= 4; i++) push_key(16'(i));
    push_key(16'd9);
    cpu_write(16'h6000, 16'h0000);
    rd(16'h6001);
    checks++;
    if (inM !== 16'h8003) begin
      failures++; $display("FAIL pre_reset_kstat got=%h exp=8003", inM);
    end
    checks++;
    if (scr_data !== 16'h5A5A) begin
      failures++; $display("FAIL pre_reset_scr got=%h exp=5a5a", scr_data);
    end
    // Writes and pushes offered during reset must be blocked.
    reset     = 1'b1;
    key_valid = 1'b1;
    key_code  = 16'd9;
    cpu_write(16'h0020, 16'h1111);
    reset     = 1'b0;
    key_valid = 1'b0;
    key_code  = 16'h0000;
    checks++;
    if (kbd_overflow !== 1'b0) begin
      failures++; $display("FAIL mid_reset_overflow got=%b exp=0", kbd_overflow);
    end
    checks++;
    if (key_ready !== 1'b1) begin
      failures++; $display("FAIL mid_reset_ready got=%b exp=1", key_ready);
    end
    checks++;
    if (scr_data !== 16'h0000) begin
      failures++; $display("FAIL mid_reset_scr got=%h exp=0000", scr_data);
    end
    rd(16'h6001);
    checks++;
    if (inM !== 16'h0000) begin
      failures++; $display("FAIL mid_reset_kstat got=%h exp=0000", inM);
    end
    rd(16'h6000);
    checks++;
    if (inM !== 16'h0000) begin
      failures++; $display("FAIL mid_reset_kbd got=%h exp=0000", inM);
    end
    rd(16'h0020);
    checks++;
    if (inM !== 16'hCAFE) begin
      failures++; $display("FAIL ram_survives_reset got=%h exp=cafe", inM);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    addressM  = 16'h0000;
    outM      = 16'h0000;
    wen       = 1'b0;
    key_valid = 1'b0;
    key_code  = 16'h0000;
    scr_addr  = 13'd0;
    test_reset();
    test_ram();
    test_screen();
    test_fifo_basic();
    test_full_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
